// File: rtl/spi_flash_loader_if.sv
// Flash-side SPI engine handshake plus the RAM write port of the ROM loader.
interface spi_flash_loader_if #(
  parameter int ADDR_W = 13
);
  logic              flash_cs_n;
  logic              spi_send;
  logic              spi_recv;
  logic [7:0]        spi_txd;
  logic [7:0]        spi_rxd;
  logic              spi_wait_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (
    output flash_cs_n, spi_send, spi_recv, spi_txd, mem_addr, mem_data, mem_we,
    input  spi_rxd, spi_wait_n
  );

  modport slave (
    input  flash_cs_n, spi_send, spi_recv, spi_txd, mem_addr, mem_data, mem_we,
    output spi_rxd, spi_wait_n
  );
endinterface

// File: rtl/spi_flash_loader.sv
// Loads a ROM image from SPI flash (READ 0x03 + 24-bit address) into RAM, one byte
// per engine handshake, and pulses done when the last byte has been written.
module spi_flash_loader #(
  parameter int ADDR_W   = 13,
  parameter int LOAD_LEN = 1024,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [23:0]        load_addr,
  output logic               busy,
  output logic               done,
  spi_flash_loader_if.master bus
);
  localparam int              GAP_W    = $clog2(CS_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'(LOAD_LEN - 1);

  typedef enum logic [3:0] {
    S_SYNC, S_IDLE, S_CS_ON, S_CMD, S_A2, S_A1, S_A0, S_RD, S_WR, S_GAP
  } state_t;

  typedef enum logic [1:0] {P_REQ, P_BSY, P_REL} phase_t;

  state_t            r_state, w_state_nxt;
  phase_t            r_ph, w_ph_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [23:0]       r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              w_ld, w_cap, w_req;
  logic              w_cs_n, w_send, w_recv, w_we;
  logic [7:0]        w_txd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
      r_ph    <= P_REQ;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_gap_nxt   = '0;
    w_ld        = 1'b0;
    w_cap       = 1'b0;
    w_req       = 1'b0;
    w_cs_n      = 1'b1;
    w_send      = 1'b0;
    w_recv      = 1'b0;
    w_txd       = 8'hFF;
    w_we        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      // The engine cannot be reset, so let any byte it is still clocking finish first
      S_SYNC: begin
        if (bus.spi_wait_n) begin
          if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
          else                   w_gap_nxt   = r_gap + GAP_W'(1);
        end
      end
      S_IDLE: begin
        if (start) begin
          w_ld        = 1'b1;
          w_state_nxt = S_CS_ON;
        end
      end
      S_CS_ON: begin
        w_cs_n      = 1'b0;
        busy        = 1'b1;
        w_state_nxt = S_CMD;
        w_ph_nxt    = P_REQ;
      end
      S_CMD, S_A2, S_A1, S_A0, S_RD: begin
        w_cs_n = 1'b0;
        busy   = 1'b1;
        w_req  = (r_ph != P_REL);
        w_send = w_req && (r_state != S_RD);
        w_recv = w_req && (r_state == S_RD);
        case (r_state)
          S_CMD:   w_txd = 8'h03;
          S_A2:    w_txd = r_addr[23:16];
          S_A1:    w_txd = r_addr[15:8];
          S_A0:    w_txd = r_addr[7:0];
          default: w_txd = 8'hFF;
        endcase
        case (r_ph)
          P_REQ: if (!bus.spi_wait_n) w_ph_nxt = P_BSY;
          P_BSY: begin
            if (bus.spi_wait_n) begin
              if (r_state == S_RD) begin
                w_cap       = 1'b1;
                w_state_nxt = S_WR;
                w_ph_nxt    = P_REQ;
              end else begin
                w_ph_nxt = P_REL;
              end
            end
          end
          default: begin
            w_ph_nxt = P_REQ;
            case (r_state)
              S_CMD:   w_state_nxt = S_A2;
              S_A2:    w_state_nxt = S_A1;
              S_A1:    w_state_nxt = S_A0;
              default: w_state_nxt = S_RD;
            endcase
          end
        endcase
      end
      // WR doubles as the one-cycle release of the read request
      S_WR: begin
        w_cs_n      = 1'b0;
        busy        = 1'b1;
        w_we        = 1'b1;
        w_state_nxt = (r_cnt == CNT_LAST) ? S_GAP : S_RD;
      end
      S_GAP: begin
        done = (r_gap == '0);
        if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
        else                   w_gap_nxt   = r_gap + GAP_W'(1);
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_gap <= w_gap_nxt;
      if (w_ld) begin
        r_addr <= load_addr;
        r_cnt  <= '0;
      end
      if (w_cap) begin
        r_mem_data <= bus.spi_rxd;
        r_mem_addr <= r_cnt[ADDR_W-1:0];
      end
      if (r_state == S_WR) r_cnt <= r_cnt + (ADDR_W + 1)'(1);
    end
  end

  assign bus.flash_cs_n = w_cs_n;
  assign bus.spi_send   = w_send;
  assign bus.spi_recv   = w_recv;
  assign bus.spi_txd    = w_txd;
  assign bus.mem_we     = w_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
endmodule
